// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the arithmetic operation sequencer:
// FSM state encoding, op codes, timer width and the response-width helper.
package arith_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } seq_state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // Wide enough for the full LAT_CYCLES range of 1..15.
   localparam int LAT_W = 4;

   function automatic int rsp_width(input int add_w, input int mul_w);
      return ((add_w + 1) > (2 * mul_w)) ? (add_w + 1) : (2 * mul_w);
   endfunction

endpackage

// File: rtl/arith_op_sequencer_if.sv
// Command, response and adder/multiplier/counter signals of the sequencer.
// master = the sequencer itself, slave = the command source and arithmetic units.
interface arith_op_sequencer_if
   import arith_seq_pkg::*;
#(
   parameter int ADD_WIDTH = 16,
   parameter int MUL_WIDTH = 8,
   parameter int TAG_WIDTH = 4
);
   localparam int RSP_W = rsp_width(ADD_WIDTH, MUL_WIDTH);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_op;
   logic [ADD_WIDTH-1:0]   cmd_opa;
   logic [ADD_WIDTH-1:0]   cmd_opb;
   logic [TAG_WIDTH-1:0]   cmd_tag;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [RSP_W-1:0]       rsp_data;
   logic                   rsp_op;
   logic [TAG_WIDTH-1:0]   rsp_tag;
   logic                   rsp_err;

   logic [ADD_WIDTH-1:0]   sys_a;
   logic [ADD_WIDTH-1:0]   sys_b;
   logic [ADD_WIDTH:0]     sys_sum;
   logic [MUL_WIDTH-1:0]   sys_mult_a;
   logic [MUL_WIDTH-1:0]   sys_mult_b;
   logic [2*MUL_WIDTH-1:0] sys_product;
   logic                   sys_enable;
   logic                   sys_overflow;

   logic                   ovf_clear;
   logic                   ovf_flag;

   modport master (
      input  cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_tag,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_err,
      input  rsp_ready,
      output sys_a, sys_b, sys_mult_a, sys_mult_b, sys_enable,
      input  sys_sum, sys_product, sys_overflow,
      input  ovf_clear,
      output ovf_flag
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_tag,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_op, rsp_tag, rsp_err,
      output rsp_ready,
      input  sys_a, sys_b, sys_mult_a, sys_mult_b, sys_enable,
      output sys_sum, sys_product, sys_overflow,
      output ovf_clear,
      input  ovf_flag
   );

endinterface

// File: rtl/arith_lat_timer.sv
// Loadable down-counter that times the settle latency of the arithmetic units.
// done is high whenever the count has reached zero.
module arith_lat_timer
   import arith_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [LAT_W-1:0] cnt_q;
   logic [LAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/arith_op_sequencer.sv
// Initiator for the adder/multiplier/counter subsystem: one command at a time is
// issued to the adder or multiplier, its result captured after LAT_CYCLES and returned.
module arith_op_sequencer
   import arith_seq_pkg::*;
#(
   parameter int ADD_WIDTH  = 16,
   parameter int MUL_WIDTH  = 8,
   parameter int LAT_CYCLES = 1,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_reset_n,
   arith_op_sequencer_if.master bus
);

   localparam int               RSP_W    = rsp_width(ADD_WIDTH, MUL_WIDTH);
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT_CYCLES - 1);

   seq_state_e             state_q, state_d;
   logic [ADD_WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [MUL_WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
   logic                   op_q, op_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic                   err_q, err_d;
   logic [RSP_W-1:0]       rsp_data_q, rsp_data_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   enable_q, enable_d;
   logic                   ovf_q, ovf_d;

   logic                   cmd_ready;
   logic                   in_issue;
   logic                   in_resp;
   logic                   cmd_fire;
   logic                   rsp_fire;
   logic                   capture;
   logic                   timer_done;

   assign cmd_fire = bus.cmd_valid && cmd_ready;
   assign rsp_fire = in_resp && bus.rsp_ready;
   assign capture  = in_issue && timer_done;

   arith_lat_timer u_timer (
      .clk      (sys_clk),
      .rst_n    (sys_reset_n),
      .load     (cmd_fire),
      .load_val (LAT_LOAD),
      .en       (in_issue),
      .done     (timer_done)
   );

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cmd_fire)   state_d = ST_ISSUE;
         ST_ISSUE: if (timer_done) state_d = ST_RESP;
         ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Ready is held low while reset is asserted even though state sits in IDLE.
   always_comb begin
      cmd_ready = (state_q == ST_IDLE) && sys_reset_n;
      in_issue  = (state_q == ST_ISSUE);
      in_resp   = (state_q == ST_RESP);
   end

   always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      op_d        = op_q;
      tag_d       = tag_q;
      err_d       = err_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
      enable_d    = rsp_fire;
      if (cmd_fire) begin
         op_d  = bus.cmd_op;
         tag_d = bus.cmd_tag;
         if (bus.cmd_op == OP_ADD) begin
            a_d   = bus.cmd_opa;
            b_d   = bus.cmd_opb;
            ma_d  = '0;
            mb_d  = '0;
            err_d = 1'b0;
         end else begin
            a_d   = '0;
            b_d   = '0;
            ma_d  = bus.cmd_opa[MUL_WIDTH-1:0];
            mb_d  = bus.cmd_opb[MUL_WIDTH-1:0];
            err_d = ((bus.cmd_opa >> MUL_WIDTH) != '0) || ((bus.cmd_opb >> MUL_WIDTH) != '0);
         end
      end
      if (capture) begin
         rsp_data_d  = (op_q == OP_MUL) ? RSP_W'(bus.sys_product) : RSP_W'(bus.sys_sum);
         rsp_valid_d = 1'b1;
      end
      if (rsp_fire) begin
         rsp_valid_d = 1'b0;
      end
   end

   // A new overflow event takes priority over a clear on the same edge.
   always_comb begin
      ovf_d = ovf_q;
      if (bus.sys_overflow) begin
         ovf_d = 1'b1;
      end else if (bus.ovf_clear) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         a_q         <= '0;
         b_q         <= '0;
         ma_q        <= '0;
         mb_q        <= '0;
         op_q        <= 1'b0;
         tag_q       <= '0;
         err_q       <= 1'b0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         enable_q    <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         op_q        <= op_d;
         tag_q       <= tag_d;
         err_q       <= err_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         enable_q    <= enable_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_op     = op_q;
   assign bus.rsp_tag    = tag_q;
   assign bus.rsp_err    = err_q;
   assign bus.sys_a      = a_q;
   assign bus.sys_b      = b_q;
   assign bus.sys_mult_a = ma_q;
   assign bus.sys_mult_b = mb_q;
   assign bus.sys_enable = enable_q;
   assign bus.ovf_flag   = ovf_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Directed bench for arith_op_sequencer: one LAT_CYCLES=1 and one LAT_CYCLES=3
// instance, responses checked against a queue of expected results.
module tb_arith_op_sequencer;

   typedef struct {
      logic [16:0] data;
      logic        op;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic        clk    = 1'b0;
   logic        rst1_n = 1'b0;
   logic        rst3_n = 1'b0;
   logic [16:0] sum3   = '0;

   always #5 clk = ~clk;

   arith_op_sequencer_if #(.ADD_WIDTH(16), .MUL_WIDTH(8), .TAG_WIDTH(4)) bus1 ();
   arith_op_sequencer_if #(.ADD_WIDTH(16), .MUL_WIDTH(8), .TAG_WIDTH(4)) bus3 ();

   // Behavioural adder/multiplier; the LAT=3 adder result is driven directly.
   assign bus1.sys_sum     = {1'b0, bus1.sys_a} + {1'b0, bus1.sys_b};
   assign bus1.sys_product = bus1.sys_mult_a * bus1.sys_mult_b;
   assign bus3.sys_sum     = sum3;
   assign bus3.sys_product = bus3.sys_mult_a * bus3.sys_mult_b;

   arith_op_sequencer #(.ADD_WIDTH(16), .MUL_WIDTH(8), .LAT_CYCLES(1), .TAG_WIDTH(4)) u_dut1 (
      .sys_clk     (clk),
      .sys_reset_n (rst1_n),
      .bus         (bus1)
   );

   arith_op_sequencer #(.ADD_WIDTH(16), .MUL_WIDTH(8), .LAT_CYCLES(3), .TAG_WIDTH(4)) u_dut3 (
      .sys_clk     (clk),
      .sys_reset_n (rst3_n),
      .bus         (bus3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Full transaction on the LAT=1 instance; hold = cycles of response backpressure.
   task automatic run1(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tag, input int hold);
      exp_t        e;
      exp_t        got;
      logic [15:0] p;
      logic [16:0] s;
      int          cyc;
      p      = a[7:0] * b[7:0];
      s      = {1'b0, a} + {1'b0, b};
      e.op   = op;
      e.tag  = tag;
      e.data = op ? {1'b0, p} : s;
      e.err  = op && ((a[15:8] != 8'h00) || (b[15:8] != 8'h00));
      sb_q.push_back(e);

      @(negedge clk);
      check("cmd_ready_idle", bus1.cmd_ready, 1);
      bus1.cmd_valid = 1'b1;
      bus1.cmd_op    = op;
      bus1.cmd_opa   = a;
      bus1.cmd_opb   = b;
      bus1.cmd_tag   = tag;
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
      bus1.cmd_op    = ~op;
      bus1.cmd_opa   = 16'hDEAD;
      bus1.cmd_opb   = 16'hBEEF;
      check("cmd_ready_busy", bus1.cmd_ready, 0);
      if (op) begin
         check("mul_sys_a_zero", bus1.sys_a, 0);
         check("mul_sys_b_zero", bus1.sys_b, 0);
         check("mul_sys_mult_a", bus1.sys_mult_a, a[7:0]);
         check("mul_sys_mult_b", bus1.sys_mult_b, b[7:0]);
      end else begin
         check("add_sys_a", bus1.sys_a, a);
         check("add_sys_b", bus1.sys_b, b);
         check("add_mult_a_zero", bus1.sys_mult_a, 0);
      end

      cyc = 1;
      while (bus1.rsp_valid !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("rsp_latency", cyc - 1, 1);

      for (int i = 0; i < hold; i++) begin
         bus1.cmd_valid = 1'b1;
         bus1.cmd_op    = 1'b0;
         bus1.cmd_opa   = 16'h0005;
         bus1.cmd_opb   = 16'h0006;
         bus1.cmd_tag   = 4'hA;
         @(negedge clk);
         check("bp_rsp_valid", bus1.rsp_valid, 1);
         check("bp_rsp_data", bus1.rsp_data, e.data);
         check("bp_cmd_ready", bus1.cmd_ready, 0);
         check("bp_enable", bus1.sys_enable, 0);
      end
      bus1.cmd_valid = 1'b0;

      check("sb_depth", sb_q.size(), 1);
      got = sb_q.pop_front();
      check("rsp_data", bus1.rsp_data, got.data);
      check("rsp_op", bus1.rsp_op, got.op);
      check("rsp_tag", bus1.rsp_tag, got.tag);
      check("rsp_err", bus1.rsp_err, got.err);
      $display("txn lat1 op=%0d a=%h b=%h tag=%0d -> data=%h err=%0d hold=%0d",
               op, a, b, tag, bus1.rsp_data, bus1.rsp_err, hold);
      bus1.rsp_ready = 1'b1;
      @(negedge clk);
      bus1.rsp_ready = 1'b0;
      check("rsp_valid_drop", bus1.rsp_valid, 0);
      check("enable_pulse", bus1.sys_enable, 1);
      check("ready_after_rsp", bus1.cmd_ready, 1);
      @(negedge clk);
      check("enable_single", bus1.sys_enable, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e3;
      exp_t got3;
      bus1.cmd_valid = 1'b0; bus1.cmd_op = 1'b0; bus1.cmd_opa = '0; bus1.cmd_opb = '0;
      bus1.cmd_tag = '0; bus1.rsp_ready = 1'b0; bus1.sys_overflow = 1'b0; bus1.ovf_clear = 1'b0;
      bus3.cmd_valid = 1'b0; bus3.cmd_op = 1'b0; bus3.cmd_opa = '0; bus3.cmd_opb = '0;
      bus3.cmd_tag = '0; bus3.rsp_ready = 1'b0; bus3.sys_overflow = 1'b0; bus3.ovf_clear = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_cmd_ready", bus1.cmd_ready, 0);
      check("rst_rsp_valid", bus1.rsp_valid, 0);
      check("rst_rsp_data", bus1.rsp_data, 0);
      check("rst_enable", bus1.sys_enable, 0);
      check("rst_ovf_flag", bus1.ovf_flag, 0);
      check("rst_sys_a", bus1.sys_a, 0);
      check("rst_sys_mult_a", bus1.sys_mult_a, 0);
      check("rst3_cmd_ready", bus3.cmd_ready, 0);
      rst1_n = 1'b1;
      rst3_n = 1'b1;
      #1;
      check("post_rst_ready1", bus1.cmd_ready, 1);
      check("post_rst_ready3", bus3.cmd_ready, 1);

      // LAT=1 transactions
      run1(1'b0, 16'hFFFF, 16'h0001, 4'd3, 0);
      run1(1'b1, 16'h00FF, 16'h00FF, 4'd5, 0);
      run1(1'b1, 16'h0102, 16'h0003, 4'd9, 0);
      run1(1'b0, 16'h1234, 16'h4321, 4'd2, 5);
      run1(1'b0, 16'h8000, 16'h8000, 4'd15, 0);

      // LAT=3: capture edge is T+3, later adder changes are not seen
      e3.data = 17'h12345; e3.op = 1'b0; e3.tag = 4'd7; e3.err = 1'b0;
      sb_q.push_back(e3);
      sum3 = 17'h00111;
      @(negedge clk);
      check("l3_cmd_ready", bus3.cmd_ready, 1);
      bus3.cmd_valid = 1'b1; bus3.cmd_op = 1'b0;
      bus3.cmd_opa = 16'h0001; bus3.cmd_opb = 16'h0002; bus3.cmd_tag = 4'd7;
      @(negedge clk);
      bus3.cmd_valid = 1'b0;
      check("l3_rsp_t1", bus3.rsp_valid, 0);
      check("l3_sys_a", bus3.sys_a, 16'h0001);
      @(negedge clk);
      check("l3_rsp_t2", bus3.rsp_valid, 0);
      sum3 = 17'h0AAAA;
      @(negedge clk);
      check("l3_rsp_t3", bus3.rsp_valid, 0);
      sum3 = 17'h12345;
      @(negedge clk);
      check("l3_rsp_valid", bus3.rsp_valid, 1);
      sum3 = 17'h00F0F;
      @(negedge clk);
      got3 = sb_q.pop_front();
      check("l3_rsp_data", bus3.rsp_data, got3.data);
      check("l3_rsp_tag", bus3.rsp_tag, got3.tag);
      check("l3_rsp_op", bus3.rsp_op, got3.op);
      check("l3_rsp_err", bus3.rsp_err, got3.err);
      $display("txn lat3 add tag=%0d -> data=%h", bus3.rsp_tag, bus3.rsp_data);
      bus3.rsp_ready = 1'b1;
      @(negedge clk);
      bus3.rsp_ready = 1'b0;
      check("l3_enable_pulse", bus3.sys_enable, 1);
      check("l3_rsp_drop", bus3.rsp_valid, 0);

      // Reset while in ISSUE discards the operation
      @(negedge clk);
      bus3.cmd_valid = 1'b1; bus3.cmd_op = 1'b1;
      bus3.cmd_opa = 16'h0010; bus3.cmd_opb = 16'h0010; bus3.cmd_tag = 4'd1;
      @(negedge clk);
      bus3.cmd_valid = 1'b0;
      @(negedge clk);
      check("mid_issue_no_rsp", bus3.rsp_valid, 0);
      rst3_n = 1'b0;
      bus3.rsp_ready = 1'b1;
      #1;
      check("mid_rst_ready", bus3.cmd_ready, 0);
      check("mid_rst_mult_a", bus3.sys_mult_a, 0);
      @(negedge clk);
      rst3_n = 1'b1;
      #1;
      check("mid_rst_ready_after", bus3.cmd_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("discard_rsp_valid", bus3.rsp_valid, 0);
         check("discard_enable", bus3.sys_enable, 0);
      end
      bus3.rsp_ready = 1'b0;
      $display("txn lat3 reset mid-issue -> discarded");

      // Sticky overflow flag
      @(negedge clk);
      check("ovf_idle", bus1.ovf_flag, 0);
      bus1.sys_overflow = 1'b1;
      bus1.ovf_clear    = 1'b1;
      @(negedge clk);
      bus1.sys_overflow = 1'b0;
      bus1.ovf_clear    = 1'b0;
      check("ovf_set_wins", bus1.ovf_flag, 1);
      @(negedge clk);
      check("ovf_sticky", bus1.ovf_flag, 1);
      bus1.ovf_clear = 1'b1;
      @(negedge clk);
      bus1.ovf_clear = 1'b0;
      check("ovf_cleared", bus1.ovf_flag, 0);
      $display("txn ovf set/clear -> flag=%0d", bus1.ovf_flag);

      check("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
